// File: rtl/bcd_down_timer.sv
// bcd_down_timer
//   Multi-digit packed-BCD countdown timer. A preset is loaded in parallel.
//   start/pause move between IDLE, RUN and PAUSED. Each tick while running
//   removes one count, with the borrow rippling through every digit in the
//   same cycle. On the terminal count the timer either stops at zero or
//   reloads the preset (AUTO_RELOAD), and done pulses for one cycle.
//
// Parameters
//   DIGITS       number of BCD digits (1..8); count width is 4*DIGITS
//   AUTO_RELOAD  1 = reload preset on terminal count and keep running
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   load      load load_val (ignored apart from err if any digit > 9)
//   load_val  packed BCD preset, digit 0 in [3:0]
//   start     begin / resume counting
//   pause     suspend counting (wins over start and tick)
//   tick      decrement qualifier while running
//   count     current value, packed BCD, registered
//   busy      state is RUN or PAUSED
//   done      one-cycle pulse on terminal count
//   zero      count == 0
//   err       sticky flag: the last load attempt held a non-BCD digit
module bcd_down_timer #(
    parameter int DIGITS      = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  zero,
    output logic                  err
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t         state;
    logic [W-1:0]   preset;
    logic [W-1:0]   dec_val;
    logic           load_ok;

    // One-cycle BCD decrement: a zero digit under borrow wraps to 9 and
    // passes the borrow on; the first non-zero digit absorbs it.
    always_comb begin
        logic borrow;
        borrow  = 1'b1;
        dec_val = count;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            preset <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // A bad preset only raises err; the running timer is untouched.
                if (load_ok) begin
                    count  <= load_val;
                    preset <= load_val;
                    state  <= IDLE;
                    err    <= 1'b0;
                end else begin
                    err    <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start && count != '0) state <= RUN;
                    end
                    RUN: begin
                        if (pause) begin
                            state <= PAUSED;
                        end else if (tick) begin
                            if (count == ONE) begin
                                done <= 1'b1;
                                if (AUTO_RELOAD) begin
                                    count <= preset;
                                end else begin
                                    count <= '0;
                                    state <= IDLE;
                                end
                            end else begin
                                count <= dec_val;
                            end
                        end
                    end
                    PAUSED: begin
                        if (start && !pause) state <= RUN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);
    assign zero = (count == '0);

endmodule

// File: tb/tb_bcd_down_timer.sv
module tb_bcd_down_timer;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   load_val = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          tick = 1'b0;

    logic [15:0]   count0, count1;
    logic          busy0, busy1, done0, done1, zero0, zero1, err0, err1;

    always #5 clk = ~clk;

    bcd_down_timer #(.DIGITS(D), .AUTO_RELOAD(1'b0)) u_stop (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .tick(tick),
        .count(count0), .busy(busy0), .done(done0), .zero(zero0), .err(err0)
    );

    bcd_down_timer #(.DIGITS(D), .AUTO_RELOAD(1'b1)) u_reload (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .tick(tick),
        .count(count1), .busy(busy1), .done(done1), .zero(zero1), .err(err1)
    );

    logic [19:0] obs [2];
    assign obs[0] = {count0, busy0, done0, zero0, err0};
    assign obs[1] = {count1, busy1, done1, zero1, err1};

    int checks = 0;
    int failures = 0;

    // Reference model: plain decimal integers, index 0 = stop, 1 = reload.
    // mst: 0 idle, 1 running, 2 paused.
    int mc [2];
    int mp [2];
    int mst [2];
    bit md [2];
    bit me [2];

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] b);
        for (int i = 0; i < D; i++)
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        int v;
        int m;
        v = 0;
        m = 1;
        for (int i = 0; i < D; i++) begin
            v = v + int'(b[4*i +: 4]) * m;
            m = m * 10;
        end
        return v;
    endfunction

    function automatic logic [19:0] mexp(input int a);
        return {to_bcd(mc[a]), mst[a] != 0, md[a], mc[a] == 0, me[a]};
    endfunction

    task automatic model_update(input int a);
        if (rst) begin
            mc[a] = 0; mp[a] = 0; mst[a] = 0; md[a] = 0; me[a] = 0;
        end else begin
            md[a] = 0;
            if (load) begin
                if (bcd_ok(load_val)) begin
                    mc[a] = from_bcd(load_val); mp[a] = mc[a]; mst[a] = 0; me[a] = 0;
                end else begin
                    me[a] = 1;
                end
            end else if (mst[a] == 0) begin
                if (start && mc[a] != 0) mst[a] = 1;
            end else if (mst[a] == 1) begin
                if (pause) mst[a] = 2;
                else if (tick) begin
                    if (mc[a] == 1) begin
                        md[a] = 1;
                        if (a == 1) mc[a] = mp[a];
                        else begin mc[a] = 0; mst[a] = 0; end
                    end else begin
                        mc[a] = mc[a] - 1;
                    end
                end
            end else begin
                if (start && !pause) mst[a] = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, land on the next negedge.
    task automatic step(input bit r, input bit l, input logic [15:0] lv,
                        input bit s, input bit p, input bit t);
        rst = r; load = l; load_val = lv; start = s; pause = p; tick = t;
        @(posedge clk);
        model_update(0);
        model_update(1);
        @(negedge clk);
        rst = 0; load = 0; start = 0; pause = 0; tick = 0;
    endtask

    task automatic test_reset();
        step(1, 0, '0, 0, 0, 0);
        for (int a = 0; a < 2; a++) begin
            checks++;
            if (obs[a] !== 20'h0_0002) begin
                failures++;
                $display("FAIL reset inst=%0d got=%h exp=%h", a, obs[a], 20'h0_0002);
            end
        end
    endtask

    task automatic test_countdown();
        int ndone;
        ndone = 0;
        step(0, 1, 16'h0012, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, '0, 0, 0, 1);
            ndone += done0;
            checks++;
            if (count0 !== to_bcd(12 - k) || obs[0] !== mexp(0)) begin
                failures++;
                $display("FAIL countdown k=%0d got=%h exp=%h", k, obs[0], mexp(0));
            end
        end
        step(0, 0, '0, 0, 0, 1);
        checks++;
        if (ndone != 1 || busy0 !== 1'b0 || zero0 !== 1'b1 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL countdown_end dones=%0d busy=%b zero=%b done=%b exp 1/0/1/0",
                     ndone, busy0, zero0, done0);
        end
    endtask

    task automatic test_borrow();
        step(0, 1, 16'h1000, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1);
        checks++;
        if (count0 !== 16'h0999 || count1 !== 16'h0999) begin
            failures++;
            $display("FAIL borrow_1000 got=%h/%h exp=0999", count0, count1);
        end
        step(0, 1, 16'h0100, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1);
        checks++;
        if (count0 !== 16'h0099 || obs[1] !== mexp(1)) begin
            failures++;
            $display("FAIL borrow_0100 got=%h exp=0099", count0);
        end
    endtask

    task automatic test_pause();
        step(0, 1, 16'h0005, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 1, 1, 1);
        checks++;
        if (count0 !== 16'h0003 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL pause_entry got=%h busy=%b exp=0003 busy=1", count0, busy0);
        end
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 1, 1, 1);
        checks++;
        if (count0 !== 16'h0003 || obs[0] !== mexp(0)) begin
            failures++;
            $display("FAIL paused_hold got=%h exp=%h", obs[0], mexp(0));
        end
        step(0, 0, '0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 1);
        checks++;
        if (count0 !== 16'h0000 || done0 !== 1'b1 || obs[1] !== mexp(1)) begin
            failures++;
            $display("FAIL resume_done got=%h done=%b exp=0000 done=1", count0, done0);
        end
    endtask

    task automatic test_illegal();
        step(0, 1, 16'h0007, 0, 0, 0);
        step(0, 1, 16'h00A3, 0, 0, 0);
        checks++;
        if (err0 !== 1'b1 || count0 !== 16'h0007) begin
            failures++;
            $display("FAIL illegal_load err=%b count=%h exp err=1 count=0007", err0, count0);
        end
        step(0, 1, 16'h0042, 0, 0, 0);
        checks++;
        if (err0 !== 1'b0 || count0 !== 16'h0042) begin
            failures++;
            $display("FAIL legal_after err=%b count=%h exp err=0 count=0042", err0, count0);
        end
        step(0, 1, 16'h0000, 0, 0, 0);
        step(0, 0, '0, 1, 0, 1);
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || zero0 !== 1'b1) begin
            failures++;
            $display("FAIL start_at_zero busy=%b/%b exp=0", busy0, busy1);
        end
    endtask

    task automatic test_auto_reload();
        logic [15:0] seq [6];
        bit          dn  [6];
        seq = '{16'h2, 16'h1, 16'h3, 16'h2, 16'h1, 16'h3};
        dn  = '{0, 0, 1, 0, 0, 1};
        step(0, 1, 16'h0003, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 0, '0, 0, 0, 1);
            checks++;
            if (count1 !== seq[k] || done1 !== dn[k] || busy1 !== 1'b1) begin
                failures++;
                $display("FAIL auto_reload k=%0d got=%h done=%b busy=%b exp=%h done=%b busy=1",
                         k, count1, done1, busy1, seq[k], dn[k]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        step(0, 1, 16'h0500, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, '0, 0, 0, 1);
        step(1, 0, '0, 0, 0, 1);
        step(0, 0, '0, 1, 0, 1);
        for (int a = 0; a < 2; a++) begin
            checks++;
            if (obs[a] !== 20'h0_0002) begin
                failures++;
                $display("FAIL reset_midrun inst=%0d got=%h exp=%h", a, obs[a], 20'h0_0002);
            end
        end
        // Load coincident with the terminal tick: load wins, no done.
        step(0, 1, 16'h0001, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        step(0, 1, 16'h0004, 0, 0, 1);
        checks++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0 || count0 !== 16'h0004) begin
            failures++;
            $display("FAIL load_vs_terminal done=%b/%b busy=%b count=%h exp 0/0/0/0004",
                     done0, done1, busy0, count0);
        end
    endtask

    task automatic test_random();
        bit r, l, s, p, t;
        logic [15:0] lv;
        int sel;
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 8);
            sel = $urandom_range(0, 3);
            if (sel == 0)      lv = 16'($urandom);
            else if (sel == 1) lv = to_bcd($urandom_range(0, 9999));
            else               lv = to_bcd($urandom_range(0, 25));
            s = ($urandom_range(0, 99) < 30);
            p = ($urandom_range(0, 99) < 8);
            t = ($urandom_range(0, 99) < 75);
            step(r, l, lv, s, p, t);
            for (int a = 0; a < 2; a++) begin
                checks++;
                if (obs[a] !== mexp(a)) begin
                    failures++;
                    $display("FAIL random n=%0d inst=%0d got=%h exp=%h", n, a, obs[a], mexp(a));
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 2; a++) begin
            mc[a] = 0; mp[a] = 0; mst[a] = 0; md[a] = 0; me[a] = 0;
        end
        @(negedge clk);
        test_reset();
        test_countdown();
        test_borrow();
        test_pause();
        test_illegal();
        test_auto_reload();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
